// File: rtl/tone_burst_if.sv
// Request/status bundle between the sound controller and the tone burst generator.
// sweep_step is present only when TONE_SWEEP_EN is defined.
interface tone_burst_if #(
  parameter int DIV_W = 20,
  parameter int DUR_W = 12
);
  logic             start;
  logic             stop;
  logic [DIV_W-1:0] half_period;
  logic [DUR_W-1:0] duration_ms;
`ifdef TONE_SWEEP_EN
  logic [7:0]       sweep_step;
`endif
  logic             busy;
  logic             done;
  logic             wave_out;

`ifdef TONE_SWEEP_EN
  modport master (output start, stop, half_period, duration_ms, sweep_step,
                  input  busy, done, wave_out);
  modport slave  (input  start, stop, half_period, duration_ms, sweep_step,
                  output busy, done, wave_out);
`else
  modport master (output start, stop, half_period, duration_ms,
                  input  busy, done, wave_out);
  modport slave  (input  start, stop, half_period, duration_ms,
                  output busy, done, wave_out);
`endif
endinterface

// File: rtl/tone_burst_generator.sv
// Square-wave tone burst source with start/busy/done handshake.
// Optional TONE_SWEEP_EN: per-ms signed half-period sweep, saturating to [1, 2^DIV_W-1].
module tone_burst_generator #(
  parameter int CLK_HZ = 100_000_000,
  parameter int DIV_W  = 20,
  parameter int DUR_W  = 12
) (
  input  logic         sys_clk,
  input  logic         reset,
  tone_burst_if.slave  bus
);
  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {IDLE, PLAY} state_t;
  state_t state, state_nxt;

  logic [DIV_W-1:0] hp_cur, hp_tgt, cnt;
  logic [DUR_W-1:0] rem;
  logic [PW-1:0]    presc;
  logic             wave_q, done_q;
  logic             load, tick, expire, run;

  // stop always beats start, so a load only happens without stop
  assign load   = bus.start && !bus.stop;
  assign tick   = (state == PLAY) && (presc == TICK_LAST);
  assign expire = tick && (rem == DUR_W'(1));
  assign run    = (state == PLAY) && !bus.stop && !expire;

`ifdef TONE_SWEEP_EN
  localparam int HP_MAX = (1 << DIV_W) - 1;
  logic [DIV_W-1:0] hp_swept;
  int               sum;
  always_comb begin
    sum = int'(hp_tgt) + int'($signed(bus.sweep_step));
    if (sum < 1)      sum = 1;
    if (sum > HP_MAX) sum = HP_MAX;
    hp_swept = DIV_W'(sum);
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load && bus.duration_ms != '0) state_nxt = PLAY;
      PLAY: begin
        if (load)                        state_nxt = (bus.duration_ms != '0) ? PLAY : IDLE;
        else if (bus.stop || expire)     state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state == PLAY);
    bus.done     = done_q;
    bus.wave_out = wave_q;
  end

  // hp_tgt collects sweep updates; hp_cur only picks them up at a counter wrap
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      hp_cur <= '0;
      hp_tgt <= '0;
      cnt    <= '0;
      rem    <= '0;
      presc  <= '0;
      wave_q <= 1'b0;
      done_q <= 1'b0;
    end else if (load) begin
      hp_cur <= bus.half_period;
      hp_tgt <= bus.half_period;
      rem    <= bus.duration_ms;
      cnt    <= '0;
      presc  <= '0;
      wave_q <= 1'b0;
      done_q <= (bus.duration_ms == '0);
    end else if (run) begin
      done_q <= 1'b0;
      if (hp_cur == '0) begin
        cnt    <= '0;
        wave_q <= 1'b0;
      end else if (cnt == hp_cur - DIV_W'(1)) begin
        cnt    <= '0;
        wave_q <= ~wave_q;
        hp_cur <= hp_tgt;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
      if (tick) begin
        presc <= '0;
        rem   <= rem - DUR_W'(1);
`ifdef TONE_SWEEP_EN
        if (hp_tgt != '0) hp_tgt <= hp_swept;
`endif
      end else begin
        presc <= presc + PW'(1);
      end
    end else begin
      done_q <= expire && !bus.stop;
      cnt    <= '0;
      rem    <= '0;
      presc  <= '0;
      wave_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tone_burst_generator.sv
// Randomized + directed bench for tone_burst_generator against an event-time model.
module tb_tone_burst_generator;
  localparam int CLK_HZ = 10_000;
  localparam int DIV_W  = 6;
  localparam int DUR_W  = 12;
  localparam int T      = CLK_HZ / 1000;
  localparam int HP_MAX = (1 << DIV_W) - 1;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;

  tone_burst_if #(.DIV_W(DIV_W), .DUR_W(DUR_W)) bus ();

  tone_burst_generator #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W), .DUR_W(DUR_W)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: time since start edge, end time, next toggle time, active/pending half-period
  bit m_busy, m_done, m_wave;
  int m_k, m_end, m_next, m_hp_act, m_hp_tgt;
  int o_busy, o_done, o_rise;
  bit prev_wave;
`ifdef TONE_SWEEP_EN
  logic [7:0] step_v = 8'd0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int s;
    if (reset) begin
      m_busy = 0; m_done = 0; m_wave = 0;
      return;
    end
    m_done = 0;
    if (bus.stop) begin
      m_busy = 0; m_wave = 0;
    end else if (bus.start) begin
      m_wave = 0;
      if (bus.duration_ms == 0) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_busy = 1; m_k = 0;
        m_end = int'(bus.duration_ms) * T;
        m_hp_act = int'(bus.half_period);
        m_hp_tgt = m_hp_act;
        m_next = m_hp_act;
      end
    end else if (m_busy) begin
      m_k++;
      if (m_k == m_end) begin
        m_busy = 0; m_wave = 0; m_done = 1;
      end else begin
        if (m_hp_act != 0 && m_k == m_next) begin
          m_wave = !m_wave;
          m_hp_act = m_hp_tgt;
          m_next = m_k + m_hp_act;
        end
`ifdef TONE_SWEEP_EN
        if (m_k % T == 0 && m_hp_tgt != 0) begin
          s = m_hp_tgt + int'($signed(bus.sweep_step));
          if (s < 1) s = 1;
          if (s > HP_MAX) s = HP_MAX;
          m_hp_tgt = s;
        end
`endif
      end
    end
  endtask

  // one clock: drive at negedge, model at posedge, compare at next negedge
  task automatic cyc(input bit st, input bit sp, input int hp, input int dur);
    bus.start = st;
    bus.stop  = sp;
    bus.half_period = DIV_W'(hp);
    bus.duration_ms = DUR_W'(dur);
`ifdef TONE_SWEEP_EN
    bus.sweep_step = step_v;
`endif
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    chk("busy", int'(bus.busy), int'(m_busy));
    chk("done", int'(bus.done), int'(m_done));
    chk("wave", int'(bus.wave_out), int'(m_wave));
    o_busy += int'(bus.busy);
    o_done += int'(bus.done);
    if (bus.wave_out && !prev_wave) o_rise++;
    prev_wave = bus.wave_out;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic clr();
    o_busy = 0; o_done = 0; o_rise = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_wave", int'(bus.wave_out), 0);

    // basic burst: 30 busy cycles, rises at 4,12,20,28
    clr(); cyc(1, 0, 4, 3); idle(32);
    chk("t1_busy_cycles", o_busy, 30);
    chk("t1_rises", o_rise, 4);
    chk("t1_done_pulses", o_done, 1);
    chk("t1_wave_end", int'(bus.wave_out), 0);

    // zero duration
    clr(); cyc(1, 0, 5, 0);
    chk("t2_done_next", int'(bus.done), 1);
    idle(3);
    chk("t2_busy_cycles", o_busy, 0);
    chk("t2_done_pulses", o_done, 1);

    // retrigger at cycle 12
    clr(); cyc(1, 0, 4, 5); idle(11); cyc(1, 0, 2, 1); idle(15);
    chk("t3_busy_cycles", o_busy, 22);
    chk("t3_done_pulses", o_done, 1);
    chk("t3_rises", o_rise, 3);

    // stop at cycle 7, then stop+start together
    clr(); cyc(1, 0, 3, 2); idle(6); cyc(0, 1, 0, 0);
    chk("t4_busy_after_stop", int'(bus.busy), 0);
    chk("t4_wave_after_stop", int'(bus.wave_out), 0);
    chk("t4_busy_cycles", o_busy, 7);
    cyc(1, 1, 3, 2);
    chk("t4_stop_wins", int'(bus.busy), 0);
    idle(3);
    chk("t4_done_pulses", o_done, 0);

    // reset mid-burst, then a normal burst
    clr(); cyc(1, 0, 2, 2); idle(5);
    reset = 1'b1; idle(1); reset = 1'b0;
    chk("t5_busy_rst", int'(bus.busy), 0);
    chk("t5_wave_rst", int'(bus.wave_out), 0);
    idle(3);
    chk("t5_done_pulses", o_done, 0);
    clr(); cyc(1, 0, 3, 1); idle(12);
    chk("t5_busy_cycles", o_busy, 10);
    chk("t5_done_after", o_done, 1);
    chk("t5_rises", o_rise, 2);

    // done and a new start in the same cycle
    clr(); cyc(1, 0, 2, 1); idle(10);
    chk("t7_done_seen", int'(bus.done), 1);
    cyc(1, 0, 2, 1);
    chk("t7_restart_busy", int'(bus.busy), 1);
    idle(12);

`ifdef TONE_SWEEP_EN
    step_v = 8'hFE;
`endif
    // silent burst keeps timing
    clr(); cyc(1, 0, 0, 2); idle(22);
    chk("t8_silent_rises", o_rise, 0);
    chk("t8_busy_cycles", o_busy, 20);
    chk("t8_done_pulses", o_done, 1);

`ifdef TONE_SWEEP_EN
    // 3 -> 1 (saturated): toggles 3,6,9,12 then every cycle to 29
    clr(); cyc(1, 0, 3, 3); idle(32);
    chk("t6_down_rises", o_rise, 11);
    chk("t6_down_busy", o_busy, 30);
    // 60 + 8 saturates at 63: toggles at 60,123,186
    step_v = 8'd8;
    clr(); cyc(1, 0, HP_MAX - 3, 20); idle(202);
    chk("t6_up_rises", o_rise, 2);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
`ifdef TONE_SWEEP_EN
      step_v = 8'($urandom_range(0, 255));
`endif
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0,
          ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, HP_MAX)) : int'($urandom_range(0, 7)),
          int'($urandom_range(0, 3)));
    end
    reset = 1'b0;
    idle(50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
